data_mem_lsu: RTL and testbench
===============================

Name: data_mem_lsu

Overview:
Load/store unit that sits directly upstream of the 8 KiB byte-addressable data memory. It accepts one byte, halfword or word access at a time from the core and drives the memory's write/byte-enable/address/data port. Accesses that straddle a word boundary are split into two sequential word accesses. Load data is aligned and sign/zero-extended before it is returned. The memory read is combinational (zero latency), so read data is sampled in the same cycle the address is driven.

Parameters:
ADDR_W, 13, byte address width; memory is 2^ADDR_W bytes and addresses wrap modulo 2^ADDR_W.

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
req_i  in  1  core request valid
gnt_o  out  1  request accepted this cycle (high only in IDLE)
we_i  in  1  1 = store, 0 = load
size_i  in  2  00 byte, 01 half, 10 word, 11 reserved
unsigned_i  in  1  zero-extend load data (0 = sign-extend)
addr_i  in  ADDR_W  byte address
wdata_i  in  32  store data, right-aligned
rvalid_o  out  1  one-cycle completion pulse (loads and stores)
rdata_o  out  32  extended load data, valid with rvalid_o; 0 for stores
err_o  out  1  reserved size, valid with rvalid_o
mem_write_o  out  1  to memory write_i
mem_be_o  out  4  to memory be_sel_i
mem_addr_o  out  ADDR_W  to memory addr_i (word-aligned, [1:0]=00)
mem_wdata_o  out  32  to memory data_i
mem_rdata_i  in  32  from memory data_o

Behaviour:
- Reset (async, rst_ni=0): state IDLE. gnt_o=1 after reset release. rvalid_o=0, rdata_o=0, err_o=0, mem_write_o=0, mem_be_o=0, mem_addr_o=0, mem_wdata_o=0. Reset mid-split leaves any already-written first word in memory; there is no rollback.
- States: IDLE, ACC0, ACC1, RESP.
- IDLE: gnt_o=1. req_i=1 latches we_i, size_i, unsigned_i, addr_i and wdata_i, then moves to ACC0. If size_i=11, it moves to RESP with err_o to be set and makes no memory access.
- Byte mask m: byte 0001, half 0011, word 1111. Offset o = addr[1:0]. Shifted 8-bit mask M = m << o. Store window W = {32'b0, wdata} << 8*o (64 bits).
- Split = |M[7:4]|.
- ACC0 (one cycle): mem_addr_o = {addr[ADDR_W-1:2], 00}. mem_be_o = M[3:0]. mem_wdata_o = W[31:0]. mem_write_o = we. Capture mem_rdata_i into lo buffer. Next state is ACC1 if split, else RESP.
- ACC1 (one cycle): mem_addr_o = {addr[ADDR_W-1:2]+1, 00}, which wraps from the top word to word 0. mem_be_o = M[7:4]. mem_wdata_o = W[63:32]. mem_write_o = we. Capture mem_rdata_i into hi buffer. Next state is RESP.
- Outside ACC0/ACC1: mem_write_o=0, mem_be_o=0. mem_addr_o and mem_wdata_o hold their last values.
- RESP (one cycle): rvalid_o=1. For loads, rdata_o = ({hi,lo} >> 8*o) truncated to the size, then zero-extended if unsigned, else sign-extended. rdata_o=0 for stores and errors. err_o=1 only for reserved size. Next state is IDLE.
- rvalid_o, rdata_o and err_o are registered. They are 0 in every cycle other than RESP.
- Latency from accepting cycle to rvalid_o: 2 cycles non-split, 3 cycles split, 1 cycle error.
- The core must hold no assumption of back-to-back grants. gnt_o=0 in ACC0/ACC1/RESP, and req_i in those states is ignored. The next grant occurs in the cycle after RESP.
- The unsigned_i value latched for stores is don't-care.

Test Plan:
- Aligned word: store 0xDEADBEEF @0x0010, then load word @0x0010 → ACC0 shows be=1111, write=1; load returns 0xDEADBEEF, rvalid_o 2 cycles after grant, err_o=0.
- Byte extension: store byte 0x80 @0x0005 (be=0010, wdata=0x00008000), then load byte signed → 0xFFFFFF80; unsigned → 0x00000080.
- Misaligned half: store half 0xA1B2 @0x0003 → ACC0 addr 0x0000 be=1000 data[31:24]=0xB2; ACC1 addr 0x0004 be=0001 data[7:0]=0xA1. Signed load returns 0xFFFFA1B2, rvalid_o 3 cycles after grant.
- Wrap: store word 0x11223344 @0x1FFE → ACC0 addr 0x1FFC be=1100; ACC1 addr 0x0000 be=0011. Word load @0x1FFE returns 0x11223344.
- Reserved size: req with size_i=11 → no mem_write_o and mem_be_o=0 throughout; rvalid_o=1 with err_o=1 in the cycle after grant; rdata_o=0.
- Reset mid-split: assert rst_ni=0 during ACC1 of a split store → all outputs 0 immediately; gnt_o=1 after release; word 0x0000 holds the ACC0 bytes only.

Source files
------------

// File: rtl/data_mem_lsu.sv
// Load/store unit in front of the byte-addressable data memory: splits
// word-straddling accesses into two word cycles and aligns/extends load data.
module data_mem_lsu #(
    parameter int ADDR_W = 13
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_i,
    output logic              gnt_o,
    input  logic              we_i,
    input  logic [1:0]        size_i,
    input  logic              unsigned_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic              rvalid_o,
    output logic [31:0]       rdata_o,
    output logic              err_o,
    output logic              mem_write_o,
    output logic [3:0]        mem_be_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic [31:0]       mem_rdata_i
);

    typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

    state_t              r_state, w_next;
    logic                r_we, r_uns;
    logic [1:0]          r_size;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_wdata, r_lo, r_hi;
    logic [ADDR_W-1:0]   r_addr_hold;
    logic [31:0]         r_wdata_hold;
    logic                r_rvalid, r_err;
    logic [31:0]         r_rdata;

    logic [3:0]          w_mask4;
    logic [7:0]          w_mask8;
    logic [63:0]         w_win;
    logic                w_split;
    logic [ADDR_W-3:0]   w_word1;
    logic [31:0]         w_lo, w_hi, w_sh, w_ext;
    logic                w_rvalid_d, w_err_d;
    logic [31:0]         w_rdata_d;

    always_comb begin
        unique case (r_size)
            2'b00:   w_mask4 = 4'b0001;
            2'b01:   w_mask4 = 4'b0011;
            2'b10:   w_mask4 = 4'b1111;
            default: w_mask4 = 4'b0000;
        endcase
    end

    assign w_mask8 = {4'b0000, w_mask4} << r_addr[1:0];
    assign w_win   = {32'b0, r_wdata} << {r_addr[1:0], 3'b000};
    assign w_split = |w_mask8[7:4];
    // Second word wraps from the top of memory back to word 0.
    assign w_word1 = r_addr[ADDR_W-1:2] + {{(ADDR_W-3){1'b0}}, 1'b1};

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= IDLE;
        else         r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: if (req_i) w_next = (size_i == 2'b11) ? RESP : ACC0;
            ACC0: w_next = w_split ? ACC1 : RESP;
            ACC1: w_next = RESP;
            RESP: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Output logic; address/data hold their last driven values when idle.
    always_comb begin
        gnt_o       = (r_state == IDLE);
        mem_write_o = 1'b0;
        mem_be_o    = 4'b0000;
        mem_addr_o  = r_addr_hold;
        mem_wdata_o = r_wdata_hold;
        unique case (r_state)
            ACC0: begin
                mem_write_o = r_we;
                mem_be_o    = w_mask8[3:0];
                mem_addr_o  = {r_addr[ADDR_W-1:2], 2'b00};
                mem_wdata_o = w_win[31:0];
            end
            ACC1: begin
                mem_write_o = r_we;
                mem_be_o    = w_mask8[7:4];
                mem_addr_o  = {w_word1, 2'b00};
                mem_wdata_o = w_win[63:32];
            end
            default: ;
        endcase
    end

    // Response is computed on the way into RESP using the word read this cycle.
    assign w_lo = (r_state == ACC0) ? mem_rdata_i : r_lo;
    assign w_hi = (r_state == ACC1) ? mem_rdata_i : r_hi;
    assign w_sh = 32'({w_hi, w_lo} >> {r_addr[1:0], 3'b000});

    always_comb begin
        unique case (r_size)
            2'b00:   w_ext = {{24{w_sh[7]  & ~r_uns}}, w_sh[7:0]};
            2'b01:   w_ext = {{16{w_sh[15] & ~r_uns}}, w_sh[15:0]};
            2'b10:   w_ext = w_sh;
            default: w_ext = 32'b0;
        endcase
    end

    assign w_rvalid_d = (w_next == RESP);
    assign w_err_d    = (r_state == IDLE) && req_i && (size_i == 2'b11);
    assign w_rdata_d  = (w_rvalid_d && (r_state != IDLE) && !r_we) ? w_ext : 32'b0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_we         <= 1'b0;
            r_uns        <= 1'b0;
            r_size       <= 2'b00;
            r_addr       <= '0;
            r_wdata      <= 32'b0;
            r_lo         <= 32'b0;
            r_hi         <= 32'b0;
            r_addr_hold  <= '0;
            r_wdata_hold <= 32'b0;
            r_rvalid     <= 1'b0;
            r_err        <= 1'b0;
            r_rdata      <= 32'b0;
        end else begin
            if (r_state == IDLE && req_i) begin
                r_we    <= we_i;
                r_uns   <= unsigned_i;
                r_size  <= size_i;
                r_addr  <= addr_i;
                r_wdata <= wdata_i;
            end
            if (r_state == ACC0) r_lo <= mem_rdata_i;
            if (r_state == ACC1) r_hi <= mem_rdata_i;
            r_addr_hold  <= mem_addr_o;
            r_wdata_hold <= mem_wdata_o;
            r_rvalid     <= w_rvalid_d;
            r_err        <= w_err_d;
            r_rdata      <= w_rdata_d;
        end
    end

    assign rvalid_o = r_rvalid;
    assign rdata_o  = r_rdata;
    assign err_o    = r_err;

endmodule

// File: tb/tb_data_mem_lsu.sv
// Directed bench for data_mem_lsu with a word-wide byte-enabled memory model.
module tb_data_mem_lsu;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        req = 1'b0;
    logic        gnt;
    logic        we = 1'b0;
    logic [1:0]  size = 2'b00;
    logic        uns = 1'b0;
    logic [12:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;
    logic        mem_write;
    logic [3:0]  mem_be;
    logic [12:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem_q [0:2047];

    int npass = 0;
    int nchk  = 0;

    // Per-access observations
    int          n_acc, lat;
    logic        any_write;
    logic [3:0]  any_be;
    logic [12:0] a_addr [0:1];
    logic [3:0]  a_be   [0:1];
    logic [31:0] a_wd   [0:1];
    logic        a_wr   [0:1];
    logic [31:0] r_data;
    logic        r_err;

    always #5 clk = ~clk;

    data_mem_lsu #(.ADDR_W(13)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .req_i(req), .gnt_o(gnt),
        .we_i(we), .size_i(size), .unsigned_i(uns), .addr_i(addr),
        .wdata_i(wdata), .rvalid_o(rvalid), .rdata_o(rdata), .err_o(err),
        .mem_write_o(mem_write), .mem_be_o(mem_be), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
    );

    assign mem_rdata = mem_q[mem_addr[12:2]];

    always @(posedge clk) begin
        if (mem_write) begin
            for (int b = 0; b < 4; b++)
                if (mem_be[b]) mem_q[mem_addr[12:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Issue one request in IDLE and watch until rvalid (bounded).
    task automatic access(input logic w, input logic [1:0] sz, input logic u,
                          input logic [12:0] a, input logic [31:0] wd);
        @(negedge clk);
        chk("gnt_idle", {31'b0, gnt}, 32'd1);
        req = 1'b1; we = w; size = sz; uns = u; addr = a; wdata = wd;
        n_acc = 0; lat = 0; any_write = 1'b0; any_be = 4'b0;
        r_data = 32'hx; r_err = 1'bx;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 1) begin
                req = 1'b0;
                chk("gnt_busy", {31'b0, gnt}, 32'd0);
            end
            any_write = any_write | mem_write;
            any_be    = any_be | mem_be;
            if (mem_be != 4'b0 || mem_write) begin
                if (n_acc < 2) begin
                    a_addr[n_acc] = mem_addr; a_be[n_acc] = mem_be;
                    a_wd[n_acc] = mem_wdata;  a_wr[n_acc] = mem_write;
                end
                n_acc++;
            end
            if (rvalid) begin
                lat = k; r_data = rdata; r_err = err;
                break;
            end
        end
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_rvalid", {31'b0, rvalid}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        chk("rst_write", {31'b0, mem_write}, 32'd0);
        chk("rst_be", {28'b0, mem_be}, 32'd0);
        chk("rst_addr", {19'b0, mem_addr}, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        @(negedge clk); @(negedge clk);
        rst_ni = 1'b1;
        @(negedge clk);
        chk("gnt_after_rst", {31'b0, gnt}, 32'd1);

        // Aligned word store/load
        access(1'b1, 2'b10, 1'b0, 13'h0010, 32'hDEADBEEF);
        chk("sw_nacc", n_acc, 1);
        chk("sw_addr", {19'b0, a_addr[0]}, 32'h10);
        chk("sw_be", {28'b0, a_be[0]}, 32'hF);
        chk("sw_wr", {31'b0, a_wr[0]}, 32'd1);
        chk("sw_wdata", a_wd[0], 32'hDEADBEEF);
        chk("sw_lat", lat, 2);
        chk("sw_rdata", r_data, 32'd0);
        chk("sw_err", {31'b0, r_err}, 32'd0);
        access(1'b0, 2'b10, 1'b0, 13'h0010, 32'h0);
        chk("lw_wr", {31'b0, any_write}, 32'd0);
        chk("lw_lat", lat, 2);
        chk("lw_rdata", r_data, 32'hDEADBEEF);
        chk("lw_err", {31'b0, r_err}, 32'd0);

        // Byte store and signed/unsigned loads
        access(1'b1, 2'b00, 1'b0, 13'h0005, 32'h00000080);
        chk("sb_addr", {19'b0, a_addr[0]}, 32'h4);
        chk("sb_be", {28'b0, a_be[0]}, 32'h2);
        chk("sb_wdata", a_wd[0], 32'h00008000);
        access(1'b0, 2'b00, 1'b0, 13'h0005, 32'h0);
        chk("lb_signed", r_data, 32'hFFFFFF80);
        access(1'b0, 2'b00, 1'b1, 13'h0005, 32'h0);
        chk("lbu", r_data, 32'h00000080);

        // Misaligned half split across words 0 and 1
        access(1'b1, 2'b01, 1'b0, 13'h0003, 32'h0000A1B2);
        chk("sh_nacc", n_acc, 2);
        chk("sh_a0", {19'b0, a_addr[0]}, 32'h0);
        chk("sh_be0", {28'b0, a_be[0]}, 32'h8);
        chk("sh_wd0", a_wd[0], 32'hB2000000);
        chk("sh_a1", {19'b0, a_addr[1]}, 32'h4);
        chk("sh_be1", {28'b0, a_be[1]}, 32'h1);
        chk("sh_wd1", a_wd[1], 32'h000000A1);
        chk("sh_lat", lat, 3);
        access(1'b0, 2'b01, 1'b0, 13'h0003, 32'h0);
        chk("lh_rdata", r_data, 32'hFFFFA1B2);
        chk("lh_lat", lat, 3);

        // Word split wrapping from the top word to word 0
        access(1'b1, 2'b10, 1'b0, 13'h1FFE, 32'h11223344);
        chk("wrap_a0", {19'b0, a_addr[0]}, 32'h1FFC);
        chk("wrap_be0", {28'b0, a_be[0]}, 32'hC);
        chk("wrap_wd0", a_wd[0], 32'h33440000);
        chk("wrap_a1", {19'b0, a_addr[1]}, 32'h0);
        chk("wrap_be1", {28'b0, a_be[1]}, 32'h3);
        chk("wrap_wd1", a_wd[1], 32'h00001122);
        access(1'b0, 2'b10, 1'b0, 13'h1FFE, 32'h0);
        chk("wrap_load", r_data, 32'h11223344);

        // Reserved size
        access(1'b1, 2'b11, 1'b0, 13'h0020, 32'h12345678);
        chk("rsv_nacc", n_acc, 0);
        chk("rsv_be", {28'b0, any_be}, 32'h0);
        chk("rsv_wr", {31'b0, any_write}, 32'd0);
        chk("rsv_lat", lat, 1);
        chk("rsv_err", {31'b0, r_err}, 32'd1);
        chk("rsv_rdata", r_data, 32'd0);

        // Reset in the middle of a split store
        access(1'b1, 2'b10, 1'b0, 13'h0000, 32'h0);
        access(1'b1, 2'b10, 1'b0, 13'h0004, 32'h0);
        @(negedge clk);
        chk("rs_gnt", {31'b0, gnt}, 32'd1);
        req = 1'b1; we = 1'b1; size = 2'b10; uns = 1'b0; addr = 13'h0002; wdata = 32'hCAFEF00D;
        @(negedge clk);
        req = 1'b0;
        chk("rs_be0", {28'b0, mem_be}, 32'hC);
        @(negedge clk);
        chk("rs_be1", {28'b0, mem_be}, 32'h3);
        rst_ni = 1'b0;
        #1;
        chk("rs_write", {31'b0, mem_write}, 32'd0);
        chk("rs_bez", {28'b0, mem_be}, 32'd0);
        chk("rs_addr", {19'b0, mem_addr}, 32'd0);
        chk("rs_wdata", mem_wdata, 32'd0);
        chk("rs_rvalid", {31'b0, rvalid}, 32'd0);
        @(negedge clk); @(negedge clk);
        rst_ni = 1'b1;
        @(negedge clk);
        chk("rs_gnt_after", {31'b0, gnt}, 32'd1);
        chk("rs_mem0", mem_q[0], 32'hF00D0000);
        chk("rs_mem1", mem_q[1], 32'h00000000);
        access(1'b0, 2'b10, 1'b0, 13'h0000, 32'h0);
        chk("rs_load0", r_data, 32'hF00D0000);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
